ifft_sdf_stage: RTL and testbench
=================================

# ifft_sdf_stage

Radix-2 single-path delay-feedback (SDF) stage for the inverse transform: the return-direction counterpart of the forward delay/butterfly stage. It consumes a serial, naturally ordered complex stream packed as {real, imag}. It emits scaled butterfly sums and conjugate-twiddled differences on one serial output. Cascaded instances, with DEPTH halving per stage, form the IFFT datapath that feeds the receive side of the capstone pipeline.

## Interface
- DEPTH, 4: delay-line length D in samples; power of two, ≥2; frame length N = 2·D.
- ROT, 0: when 1, difference samples with index k in [D/2, D) are multiplied by +j (conjugate of W4^1). This is the exact twiddle when D=2; larger stages leave twiddles to a downstream multiplier.
- n, 16: packed sample width; real = upper n/2 bits, imag = lower n/2 bits, both two's-complement.

Ports:
- clk  in  1  single clock, rising-edge.
- clear  in  1  asynchronous, active-low reset.
- din  in  n  packed input sample {re, im}.
- in_valid  in  1  din is valid this cycle; all state advances only on in_valid=1.
- dout_r  out  n/2  real part of output sample (registered).
- dout_im  out  n/2  imag part of output sample (registered).
- out_valid  out  1  dout_r/dout_im carry a valid sample.
- out_sof  out  1  high with the first sum output (k=0) of each frame.

## Operation
- Sample counter cnt, log2(D)+1 bits, increments on each in_valid and wraps at N. Phase = cnt MSB; index k = cnt low bits.
- Phase 0 (input samples x[k], k<D): the input is written into the delay line. The delay-line head is emitted: the previous frame's stored difference, rotated if ROT applies to index k.
- Phase 1 (input x[k+D]): the butterfly combines delay-line head a = x[k] with input b = x[k+D].
  - s = (a+b)>>>1 goes to the output.
  - d = (a−b)>>>1 goes into the delay line.
- Arithmetic is per component. The sum/difference is computed at n/2+1 bits, then arithmetically shifted right by 1, truncating toward −∞. The n/2-bit result cannot overflow.
- +j rotation: (re, im) → (−im, re). Negation of −2^(n/2−1) saturates to 2^(n/2−1)−1.
- Per-frame output order: sums k=0..D−1, then, during the next frame's phase 0, differences k=0..D−1.
- primed flag: cleared by reset, set on the first phase-1 input. Phase-0 outputs before primed=1 are not flagged valid, because the delay line holds reset zeros.
- The last frame's differences emerge only as further inputs arrive; the upstream block flushes with D zero samples.
- in_valid=0 holds all state, including cnt, the delay line and outputs; out_valid drops to 0.

## Timing
- Reset (clear=0, asynchronous) forces the following:
  - cnt=0, primed=0;
  - delay line all zero;
  - dout_r=0, dout_im=0, out_valid=0, out_sof=0.
- Reset released mid-frame discards the partial frame; the next in_valid sample is x[0] of a new frame.
- Outputs are registered. The result for the input accepted on edge t appears after edge t, so out_valid is high in the following cycle.
- out_valid = registered (in_valid & (primed | phase==1)). The first valid output follows the (D+1)th accepted input.
- Latency: x[k+D] → sum output is 1 clock. x[k+D] → difference output is D accepted inputs + 1 clock.
- out_sof = registered (in_valid & phase==1 & k==0).
- Back-to-back frames give a continuous output stream with no bubbles. Gaps in in_valid appear as equal gaps in out_valid.

## Test plan
- Basic butterfly (D=4, ROT=0): re = 10,20,30,40,50,60,70,80, im=0, then 4 zeros.
  - Sums re = 30,40,50,60 with out_sof on 30.
  - Then differences re = −20,−20,−20,−20; im=0 throughout.
- Rotation (D=4, ROT=1), same stimulus: differences are (−20,0), (−20,0), (0,−20), (0,−20).
- Rounding: a=(3,−3), b=(0,0) at D=2 → sum (1,−2), difference (1,−2).
- Saturation (D=2, ROT=1, n=16):
  - x[0]=(0,−128), x[1]=(0,−128), x[2]=(0,127), x[3]=(0,127).
  - Difference k=1: (0,−128) rotates to (127,0).
- Stall and reset:
  - in_valid toggled 1/0 each cycle: outputs match the basic test at half rate, with out_valid alternating.
  - clear pulsed low after 5 inputs: all outputs are 0 immediately, and no out_valid appears until the (D+1)th new input.

Source files
------------

// File: rtl/ifft_sdf_stage.sv
// Radix-2 single-path delay-feedback stage for the inverse transform.
// Emits halved butterfly sums directly and replays halved differences,
// optionally rotated by +j, during the following frame's first half.
module ifft_sdf_stage #(
  parameter int unsigned DEPTH = 4,
  parameter bit          ROT   = 1'b0,
  parameter int unsigned n     = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [n-1:0]     din,
  input  logic             in_valid,
  output logic [n/2-1:0]   dout_r,
  output logic [n/2-1:0]   dout_im,
  output logic             out_valid,
  output logic             out_sof
);

  localparam int unsigned HW = n / 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned KW = CW - 1;

  // (a +/- b) at HW+1 bits, arithmetic shift right by one (floor)
  function automatic logic [HW-1:0] half_op(input logic [HW-1:0] a,
                                            input logic [HW-1:0] b,
                                            input logic          sub);
    logic [HW:0] ea;
    logic [HW:0] eb;
    logic [HW:0] e;
    ea = {a[HW-1], a};
    eb = {b[HW-1], b};
    e  = sub ? (ea - eb) : (ea + eb);
    return e[HW:1];
  endfunction

  // Two's-complement negation; the most negative value saturates
  function automatic logic [HW-1:0] sat_neg(input logic [HW-1:0] x);
    if (x == {1'b1, {(HW-1){1'b0}}}) return {1'b0, {(HW-1){1'b1}}};
    return ~x + HW'(1);
  endfunction

  logic [CW-1:0] r_cnt;
  logic          r_primed;
  logic [HW-1:0] r_dl_re [DEPTH];
  logic [HW-1:0] r_dl_im [DEPTH];

  logic          w_phase;
  logic [KW-1:0] w_k;
  logic [HW-1:0] w_in_re, w_in_im;
  logic [HW-1:0] w_head_re, w_head_im;
  logic          w_rot;
  logic [HW-1:0] w_emit_re, w_emit_im;
  logic [HW-1:0] w_push_re, w_push_im;

  assign w_phase   = r_cnt[CW-1];
  assign w_k       = r_cnt[KW-1:0];
  assign w_in_re   = din[n-1:HW];
  assign w_in_im   = din[HW-1:0];
  assign w_head_re = r_dl_re[0];
  assign w_head_im = r_dl_im[0];
  assign w_rot     = ROT && (w_k >= KW'(DEPTH / 2));

  // Select the sample to emit and the value to feed back into the delay line
  always_comb begin
    w_emit_re = w_head_re;
    w_emit_im = w_head_im;
    w_push_re = w_in_re;
    w_push_im = w_in_im;
    if (w_phase) begin
      w_emit_re = half_op(w_head_re, w_in_re, 1'b0);
      w_emit_im = half_op(w_head_im, w_in_im, 1'b0);
      w_push_re = half_op(w_head_re, w_in_re, 1'b1);
      w_push_im = half_op(w_head_im, w_in_im, 1'b1);
    end else if (w_rot) begin
      w_emit_re = sat_neg(w_head_im);
      w_emit_im = w_head_re;
    end
  end

  // Sample counter and primed flag; counter wraps naturally at 2*DEPTH
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (in_valid) begin
      r_cnt    <= r_cnt + CW'(1);
      r_primed <= r_primed | w_phase;
    end
  end

  // Delay line: FIFO of DEPTH samples, head at index 0
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_dl_re[i] <= '0;
        r_dl_im[i] <= '0;
      end
    end else if (in_valid) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        r_dl_re[i] <= r_dl_re[i+1];
        r_dl_im[i] <= r_dl_im[i+1];
      end
      r_dl_re[DEPTH-1] <= w_push_re;
      r_dl_im[DEPTH-1] <= w_push_im;
    end
  end

  // Registered output sample and flags; data holds while stalled
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      dout_r    <= '0;
      dout_im   <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else if (in_valid) begin
      dout_r    <= w_emit_re;
      dout_im   <= w_emit_im;
      out_valid <= r_primed | w_phase;
      out_sof   <= w_phase && (w_k == '0);
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifft_sdf_stage.sv
// Directed bench for ifft_sdf_stage: three instances (D=4/ROT=0, D=4/ROT=1,
// D=2/ROT=1) checked through per-instance expected-output queues.
module tb_ifft_sdf_stage;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       sof;
  } exp_t;

  logic        clk;
  logic        clear;
  logic [15:0] din_a, din_b, din_c;
  logic        v_a, v_b, v_c;
  logic [7:0]  r_a, i_a, r_b, i_b, r_c, i_c;
  logic        ov_a, ov_b, ov_c;
  logic        sof_a, sof_b, sof_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int n_tests = 0;
  int n_fail  = 0;

  int xs[12] = '{10, 20, 30, 40, 50, 60, 70, 80, 0, 0, 0, 0};
  int c_re[10] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int c_im[10] = '{-3, 0, 0, 0, -128, -128, 127, 127, 0, 0};
  int ce_re[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 127};
  int ce_im[10] = '{0, 0, -2, 0, -2, 0, -1, -1, -128, 0};

  ifft_sdf_stage #(.DEPTH(4), .ROT(1'b0), .n(16)) u_a (
    .clk(clk), .clear(clear), .din(din_a), .in_valid(v_a),
    .dout_r(r_a), .dout_im(i_a), .out_valid(ov_a), .out_sof(sof_a));

  ifft_sdf_stage #(.DEPTH(4), .ROT(1'b1), .n(16)) u_b (
    .clk(clk), .clear(clear), .din(din_b), .in_valid(v_b),
    .dout_r(r_b), .dout_im(i_b), .out_valid(ov_b), .out_sof(sof_b));

  ifft_sdf_stage #(.DEPTH(2), .ROT(1'b1), .n(16)) u_c (
    .clk(clk), .clear(clear), .din(din_c), .in_valid(v_c),
    .dout_r(r_c), .dout_im(i_c), .out_valid(ov_c), .out_sof(sof_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic push(input int inst, input int re, input int im, input bit sof);
    exp_t e;
    e.re  = 8'(re);
    e.im  = 8'(im);
    e.sof = sof;
    case (inst)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output for basic stimulus index i (sums for 4..7, differences for 8..11)
  task automatic push_basic(input int inst, input int i, input bit rot);
    if (i >= 4 && i < 8) push(inst, 30 + 10 * (i - 4), 0, i == 4);
    else if (i >= 8) begin
      if (rot && i >= 10) push(inst, 0, -20, 1'b0);
      else                push(inst, -20, 0, 1'b0);
    end
  endtask

  // Scoreboard monitors: compare every valid output against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (ov_a) begin
      if (q_a.size() == 0) chk("a_spurious_valid", 8'(ov_a), 8'(0));
      else begin
        e = q_a.pop_front();
        chk("a_re", r_a, e.re);
        chk("a_im", i_a, e.im);
        chk("a_sof", 8'(sof_a), 8'(e.sof));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov_b) begin
      if (q_b.size() == 0) chk("b_spurious_valid", 8'(ov_b), 8'(0));
      else begin
        e = q_b.pop_front();
        chk("b_re", r_b, e.re);
        chk("b_im", i_b, e.im);
        chk("b_sof", 8'(sof_b), 8'(e.sof));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov_c) begin
      if (q_c.size() == 0) chk("c_spurious_valid", 8'(ov_c), 8'(0));
      else begin
        e = q_c.pop_front();
        chk("c_re", r_c, e.re);
        chk("c_im", i_c, e.im);
        chk("c_sof", 8'(sof_c), 8'(e.sof));
      end
    end
  end

  initial begin
    clear = 1'b0;
    din_a = '0; din_b = '0; din_c = '0;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    #3;
    // Reset state of every instance
    chk("rst_a_re", r_a, 8'd0);   chk("rst_a_im", i_a, 8'd0);
    chk("rst_a_ov", 8'(ov_a), 8'd0); chk("rst_a_sof", 8'(sof_a), 8'd0);
    chk("rst_b_re", r_b, 8'd0);   chk("rst_b_im", i_b, 8'd0);
    chk("rst_b_ov", 8'(ov_b), 8'd0); chk("rst_b_sof", 8'(sof_b), 8'd0);
    chk("rst_c_re", r_c, 8'd0);   chk("rst_c_im", i_c, 8'd0);
    chk("rst_c_ov", 8'(ov_c), 8'd0); chk("rst_c_sof", 8'(sof_c), 8'd0);
    repeat (2) tick();
    clear = 1'b1;
    tick();

    // Basic butterfly (ROT=0) and rotation (ROT=1) with identical stimulus
    for (int i = 0; i < 12; i++) begin
      din_a = {8'(xs[i]), 8'h00};
      din_b = {8'(xs[i]), 8'h00};
      v_a = 1'b1; v_b = 1'b1;
      push_basic(0, i, 1'b0);
      push_basic(1, i, 1'b1);
      tick();
    end
    v_a = 1'b0; v_b = 1'b0;
    tick();

    // Rounding frame then saturation frame on D=2, ROT=1, followed by flush
    for (int i = 0; i < 10; i++) begin
      din_c = {8'(c_re[i]), 8'(c_im[i])};
      v_c = 1'b1;
      if (i >= 2) push(2, ce_re[i], ce_im[i], i == 2 || i == 6);
      tick();
    end
    v_c = 1'b0;
    tick();

    // Stall: in_valid alternates 1/0, outputs follow at half rate
    clear = 1'b0; #1; clear = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      din_a = {8'(xs[i]), 8'h00};
      v_a = 1'b1;
      push_basic(0, i, 1'b0);
      tick();
      v_a = 1'b0;
      tick();
      chk("stall_gap_ov", 8'(ov_a), 8'd0);
    end
    tick();

    // Reset mid-frame: five inputs, asynchronous clear, then a fresh frame
    clear = 1'b0; #1; clear = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      din_a = {8'(xs[i]), 8'h00};
      v_a = 1'b1;
      if (i == 4) push(0, 30, 0, 1'b1);
      tick();
    end
    v_a = 1'b0;
    @(negedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("midrst_re", r_a, 8'd0);
    chk("midrst_im", i_a, 8'd0);
    chk("midrst_ov", 8'(ov_a), 8'd0);
    chk("midrst_sof", 8'(sof_a), 8'd0);
    clear = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      din_a = {8'(xs[i]), 8'h00};
      v_a = 1'b1;
      push_basic(0, i, 1'b0);
      tick();
    end
    v_a = 1'b0;
    repeat (3) tick();

    // Every expected output must have been produced
    chk("a_queue_drained", 8'(q_a.size()), 8'd0);
    chk("b_queue_drained", 8'(q_b.size()), 8'd0);
    chk("c_queue_drained", 8'(q_c.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
